// File: rtl/ex_stage_pipe.sv
// Execute stage with valid/ready handshakes: single-cycle ALU ops, a multi-cycle multiply,
// result flags, destination-tag passthrough and a flush that kills in-flight work.
module ex_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int IMM_W      = 16,
    parameter int TAG_W      = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] reg1_data,
    input  logic [DATA_W-1:0] reg2_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic              imm_sext,
    input  logic              alu_src,
    input  logic [3:0]        alu_op,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic [TAG_W-1:0]  tag_out,
    output logic              zero,
    output logic              overflow,
    output logic              illegal
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [TAG_W-1:0]  mul_tag;
    logic [DATA_W-1:0] mul_prod;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_comb;
    logic              ovf_comb;
    logic              ill_comb;
    logic              accept;

    assign imm_ext   = {{(DATA_W-IMM_W){imm_sext & imm[IMM_W-1]}}, imm};
    assign operand_b = alu_src ? imm_ext : reg2_data;
    assign sum       = reg1_data + operand_b;
    assign diff      = reg1_data - operand_b;
    assign mul_prod  = mul_a * mul_b;

    assign out_valid = (state == S_HOLD);
    assign in_ready  = (state != S_MUL) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && !flush;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        alu_comb = '0;
        ovf_comb = 1'b0;
        ill_comb = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_comb = sum;
                ovf_comb = (reg1_data[DATA_W-1] == operand_b[DATA_W-1]) &&
                           (sum[DATA_W-1] != reg1_data[DATA_W-1]);
            end
            OP_SUB: begin
                alu_comb = diff;
                ovf_comb = (reg1_data[DATA_W-1] != operand_b[DATA_W-1]) &&
                           (diff[DATA_W-1] != reg1_data[DATA_W-1]);
            end
            OP_AND:  alu_comb = reg1_data & operand_b;
            OP_OR:   alu_comb = reg1_data | operand_b;
            OP_XOR:  alu_comb = reg1_data ^ operand_b;
            OP_SLL:  alu_comb = reg1_data << operand_b[SH_W-1:0];
            OP_SRL:  alu_comb = reg1_data >> operand_b[SH_W-1:0];
            OP_SRA:  alu_comb = $signed(reg1_data) >>> operand_b[SH_W-1:0];
            OP_SLT:  alu_comb = {{(DATA_W-1){1'b0}}, $signed(reg1_data) < $signed(operand_b)};
            OP_SLTU: alu_comb = {{(DATA_W-1){1'b0}}, reg1_data < operand_b};
            OP_MUL:  alu_comb = '0;
            default: ill_comb = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            alu_result <= '0;
            tag_out    <= '0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            illegal    <= 1'b0;
            // NOTE: multiply operand/tag registers are pure datapath and are deliberately left unreset.
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (accept) begin
            if (alu_op == OP_MUL) begin
                state   <= S_MUL;
                cnt     <= CNT_LOAD;
                mul_a   <= reg1_data;
                mul_b   <= operand_b;
                mul_tag <= tag_in;
            end else begin
                state      <= S_HOLD;
                alu_result <= alu_comb;
                tag_out    <= tag_in;
                zero       <= (alu_comb == '0);
                overflow   <= ovf_comb;
                illegal    <= ill_comb;
            end
        end else if (state == S_MUL) begin
            // Counter starts at MUL_CYCLES-2 so the result lands MUL_CYCLES-1 edges after accept.
            if (cnt == '0) begin
                state      <= S_HOLD;
                alu_result <= mul_prod;
                tag_out    <= mul_tag;
                zero       <= (mul_prod == '0);
                overflow   <= 1'b0;
                illegal    <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (out_valid && out_ready) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_ex_stage_pipe;
    localparam int MUL_CYCLES = 4;
    localparam bit [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_SRA = 4'd7;
    localparam bit [3:0] OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] reg1_data, reg2_data;
    logic [15:0] imm;
    logic        imm_sext, alu_src;
    logic [3:0]  alu_op;
    logic [4:0]  tag_in, tag_out;
    logic        out_valid, out_ready;
    logic [31:0] alu_result;
    logic        zero, overflow, illegal;

    ex_stage_pipe #(.DATA_W(32), .IMM_W(16), .TAG_W(5), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .reg1_data(reg1_data), .reg2_data(reg2_data), .imm(imm),
        .imm_sext(imm_sext), .alu_src(alu_src), .alu_op(alu_op), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .tag_out(tag_out),
        .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        zero;
        logic        ovf;
        logic        ill;
    } exp_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    bit   m_has = 1'b0;
    bit   m_clear = 1'b1;
    int   m_ready = 0;
    exp_t m_item;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    // Reference result computed from the operation's arithmetic meaning on 64-bit integers.
    function automatic exp_t ref_op(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b_reg,
                                    input bit [15:0] im, input bit src, input bit sx,
                                    input bit [4:0] tg);
        exp_t           e;
        longint         sa, sb, s, lim;
        longint unsigned ua, ub, p;
        bit [31:0]      b;
        if (src) b = (sx && im >= 16'h8000) ? 32'(longint'(im) - 65536) : {16'h0, im};
        else     b = b_reg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        lim = 64'sd2147483648;
        e = '0;
        e.tag = tg;
        case (op)
            4'd0: begin s = sa + sb; e.res = s[31:0]; e.ovf = (s >= lim) || (s < -lim); end
            4'd1: begin s = sa - sb; e.res = s[31:0]; e.ovf = (s >= lim) || (s < -lim); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: begin p = ua << (ub % 32); e.res = p[31:0]; end
            4'd6: begin p = ua >> (ub % 32); e.res = p[31:0]; end
            4'd7: begin s = sa >>> (ub % 32); e.res = s[31:0]; end
            4'd8: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: e.res = (ua < ub) ? 32'd1 : 32'd0;
            4'd10: begin p = ua * ub; e.res = p[31:0]; end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic compare_outputs();
        bit exp_valid;
        exp_valid = m_has && (cyc >= m_ready);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            m_clear = 1'b0;
            check("alu_result", alu_result, m_item.res);
            check("tag_out", tag_out, m_item.tag);
            check("zero", zero, m_item.zero);
            check("overflow", overflow, m_item.ovf);
            check("illegal", illegal, m_item.ill);
        end else if (m_clear) begin
            check("cleared_outputs", {alu_result, tag_out, zero, overflow, illegal}, 64'd0);
        end
    endtask

    // One clock cycle: drive at the falling edge, predict, cross the rising edge, compare.
    task automatic step(input bit v, input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                        input bit [15:0] im, input bit src, input bit sx, input bit [4:0] tg,
                        input bit ordy, input bit fl, input bit rs);
        bit exp_valid, exp_rdy, acc;
        in_valid = v;  alu_op = op;  reg1_data = a;  reg2_data = b;  imm = im;
        alu_src = src; imm_sext = sx; tag_in = tg;   out_ready = ordy;
        flush = fl;    reset = rs;
        #1;
        exp_valid = m_has && (cyc >= m_ready);
        exp_rdy   = !(m_has && cyc < m_ready) && (!exp_valid || ordy);
        check("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy && rs && !fl;
        if (!rs) begin
            m_has = 1'b0;
            m_clear = 1'b1;
        end else if (fl) begin
            m_has = 1'b0;
        end else if (acc) begin
            m_has = 1'b1;
            m_item = ref_op(op, a, b, im, src, sx, tg);
            m_ready = cyc + ((op == OP_MUL) ? MUL_CYCLES : 1);
        end else if (exp_valid && ordy) begin
            m_has = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 5'd0, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        bit [31:0] ra, rb;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        reg1_data = '0; reg2_data = '0; imm = '0; imm_sext = 1'b0; alu_src = 1'b0;
        alu_op = '0; tag_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        compare_outputs();

        // R-type ADD then SUB back-to-back
        step(1, OP_ADD, 32'd10, 32'd5, 16'd0, 0, 0, 5'd1, 1, 0, 1);
        check("add_lit", alu_result, 32'd15);
        step(1, OP_SUB, 32'd10, 32'd5, 16'd0, 0, 0, 5'd2, 1, 0, 1);
        check("sub_lit", alu_result, 32'd5);
        check("sub_flags", {zero, overflow}, 2'b00);

        // Immediate extension
        step(1, OP_ADD, 32'd10, 32'd0, 16'hFFF8, 1, 1, 5'd3, 1, 0, 1);
        check("imm_sext_lit", alu_result, 32'd2);
        step(1, OP_ADD, 32'd10, 32'd0, 16'hFFF8, 1, 0, 5'd3, 1, 0, 1);
        check("imm_zext_lit", alu_result, 32'h0001_0002);
        step(1, OP_AND, 32'hFF, 32'd0, 16'hFFF8, 1, 0, 5'd3, 1, 0, 1);
        check("and_imm_lit", alu_result, 32'hF8);

        // Overflow, compares, arithmetic shift
        step(1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 16'd0, 0, 0, 5'd4, 1, 0, 1);
        check("ovf_lit", {alu_result, overflow}, {32'h8000_0000, 1'b1});
        step(1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 16'd0, 0, 0, 5'd4, 1, 0, 1);
        check("slt_lit", alu_result, 32'd1);
        step(1, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 16'd0, 0, 0, 5'd4, 1, 0, 1);
        check("sltu_lit", {alu_result, zero}, {32'd0, 1'b1});
        step(1, OP_SRA, 32'h8000_0000, 32'h21, 16'd0, 0, 0, 5'd4, 1, 0, 1);
        check("sra_lit", alu_result, 32'hC000_0000);

        // Multiply latency and result
        step(1, OP_MUL, 32'd7, 32'hFFFF_FFFD, 16'd0, 0, 0, 5'd9, 1, 0, 1);
        for (int i = 1; i < MUL_CYCLES; i++) begin
            check("mul_busy_ready", {in_ready, out_valid}, 2'b00);
            step(1, OP_ADD, 32'd1, 32'd1, 16'd0, 0, 0, 5'd0, 1, 0, 1);
        end
        check("mul_lit", {out_valid, alu_result, tag_out}, {1'b1, 32'hFFFF_FFEB, 5'd9});

        // Backpressure then release with a same-edge accept
        step(1, OP_ADD, 32'd100, 32'd23, 16'd0, 0, 0, 5'd5, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, OP_SUB, 32'd50, 32'd8, 16'd0, 0, 0, 5'd6, 0, 0, 1);
            check("stall_hold", {in_ready, alu_result, tag_out}, {1'b0, 32'd123, 5'd5});
        end
        step(1, OP_SUB, 32'd50, 32'd8, 16'd0, 0, 0, 5'd6, 1, 0, 1);
        check("release_lit", {out_valid, alu_result, tag_out}, {1'b1, 32'd42, 5'd6});

        // Flush two cycles into a multiply
        idle(1);
        step(1, OP_MUL, 32'd3, 32'd3, 16'd0, 0, 0, 5'd7, 1, 0, 1);
        idle(1);
        step(0, 4'd0, 32'd0, 32'd0, 16'd0, 0, 0, 5'd0, 1, 1, 1);
        check("flush_idle", {out_valid, in_ready}, 2'b01);
        repeat (MUL_CYCLES) idle(1);

        // Reset in HOLD, then an illegal op
        step(1, OP_ADD, 32'd5, 32'd6, 16'd0, 0, 0, 5'd8, 0, 0, 1);
        step(0, 4'd0, 32'd0, 32'd0, 16'd0, 0, 0, 5'd0, 0, 0, 0);
        check("reset_hold_clear", {out_valid, alu_result, tag_out, zero, overflow, illegal}, 64'd0);
        step(1, 4'd12, 32'd5, 32'd6, 16'd0, 0, 0, 5'd10, 1, 0, 1);
        check("illegal_lit", {alu_result, zero, illegal, overflow}, {32'd0, 1'b1, 1'b1, 1'b0});

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h7FFF_FFFF;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = ra;
                default: ;
            endcase
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), ra, rb,
                 16'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
                 !($urandom_range(0, 199) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
